// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM block.
// Contents:
//   PWM_EDGE / PWM_CENTER  alignment mode encodings (value of mode_center)
//   CW_DEF                 default counter/duty/period width
//   pwm_dir_e              counter direction used in centre-aligned mode
//   sweep_next()           next duty value for the auto-sweep, including the
//                          rule that a sum beyond the period restarts at 0
package pwm_pkg;

  localparam logic PWM_EDGE   = 1'b0;
  localparam logic PWM_CENTER = 1'b1;

  localparam int CW_DEF = 8;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

  // The sum is formed one bit wider than the operands so a carry out of the
  // duty width still counts as "beyond the period" and restarts the sweep at 0
  // instead of wrapping to a small duty value.
  function automatic logic [31:0] sweep_next(input logic [31:0] duty,
                                             input logic [31:0] step,
                                             input logic [31:0] period);
    logic [32:0] nxt;
    nxt = {1'b0, duty} + {1'b0, step};
    if (nxt <= {1'b0, period}) return nxt[31:0];
    return 32'd0;
  endfunction

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM compare channel: duty shadow register, active duty register and the
// registered compare output.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   en           run enable; output forced low while 0
//   load         load the active duty from the shadow (boundary or idle)
//   sweep_load   replace the active duty with its swept value instead
//   wr_hit       a duty write addressed to this channel is present
//   wr_duty      value of that write
//   sweep_step   sweep increment
//   period       incoming period value, the sweep's upper limit
//   cnt          shared period counter
//   pwm_out      registered (cnt < duty_act)
module pwm_channel_cmp
  import pwm_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic          sweep_load,
  input  logic          wr_hit,
  input  logic [CW-1:0] wr_duty,
  input  logic [CW-1:0] sweep_step,
  input  logic [CW-1:0] period,
  input  logic [CW-1:0] cnt,
  output logic          pwm_out
);

  logic [CW-1:0] duty_shadow_q, duty_shadow_d;
  logic [CW-1:0] duty_act_q, duty_act_d;
  logic          pwm_q, pwm_d;

  // Loading from duty_shadow_d rather than duty_shadow_q lets a write that
  // lands on the boundary clock reach the active duty without waiting a cycle.
  always_comb begin
    duty_shadow_d = wr_hit ? wr_duty : duty_shadow_q;
    duty_act_d    = duty_act_q;
    if (sweep_load) begin
      duty_act_d = CW'(sweep_next(32'(duty_act_q), 32'(sweep_step), 32'(period)));
    end else if (load) begin
      duty_act_d = duty_shadow_d;
    end
    pwm_d = en && (cnt < duty_act_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_shadow_q <= '0;
      duty_act_q    <= '0;
      pwm_q         <= 1'b0;
    end else begin
      duty_shadow_q <= duty_shadow_d;
      duty_act_q    <= duty_act_d;
      pwm_q         <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: one shared period counter feeding CH compare
// channels, edge- or centre-aligned, with double-buffered duty/period/mode and
// an optional per-cycle duty sweep.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   en            run enable
//   mode_center   0 edge-aligned, 1 centre-aligned (taken at cycle boundary)
//   period        period value (taken at cycle boundary)
//   wr_en, wr_ch, wr_duty   duty shadow write; out-of-range wr_ch ignored
//   sweep_en, sweep_step    per-cycle duty auto-sweep
//   pwm_out       registered PWM outputs, one per channel
//   cyc_done      high during the last count of each PWM cycle
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int CH  = 4,
  parameter int CW  = CW_DEF,
  parameter int CHW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           mode_center,
  input  logic [CW-1:0]  period,
  input  logic           wr_en,
  input  logic [CHW-1:0] wr_ch,
  input  logic [CW-1:0]  wr_duty,
  input  logic           sweep_en,
  input  logic [CW-1:0]  sweep_step,
  output logic [CH-1:0]  pwm_out,
  output logic           cyc_done
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] period_act_q, period_act_d;
  logic          mode_act_q, mode_act_d;
  pwm_dir_e      dir_q, dir_d;
  logic          tc, boundary, load, sweep_load;
  logic [CH-1:0] wr_hit;

  // Centre mode normally ends on cnt==1 while counting down; with a period of
  // 0 or 1 there is no down leg, so the cycle ends at the top of the up leg.
  // Idle and boundary clocks both restart the count and re-latch period/mode.
  always_comb begin
    if (mode_act_q == PWM_CENTER) begin
      tc = ((dir_q == DIR_DOWN) && (cnt_q == CW'(1))) ||
           ((dir_q == DIR_UP) && (cnt_q == period_act_q) && (period_act_q <= CW'(1)));
    end else begin
      tc = (cnt_q == period_act_q);
    end
    boundary   = en && tc;
    load       = !en || boundary;
    sweep_load = boundary && sweep_en;
    cyc_done   = boundary && !rst;

    cnt_d        = cnt_q;
    dir_d        = dir_q;
    period_act_d = period_act_q;
    mode_act_d   = mode_act_q;
    if (load) begin
      cnt_d        = '0;
      dir_d        = DIR_UP;
      period_act_d = period;
      mode_act_d   = mode_center;
    end else if (mode_act_q == PWM_EDGE) begin
      cnt_d = cnt_q + CW'(1);
    end else if (dir_q == DIR_UP) begin
      if (cnt_q == period_act_q) begin
        dir_d = DIR_DOWN;
        cnt_d = cnt_q - CW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      dir_q        <= DIR_UP;
      period_act_q <= '0;
      mode_act_q   <= PWM_EDGE;
    end else begin
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      period_act_q <= period_act_d;
      mode_act_q   <= mode_act_d;
    end
  end

  // Only indices below CH get a decoder output, so writes to a wider index
  // simply match nothing.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign wr_hit[i] = wr_en && (32'(wr_ch) == 32'(i));

    pwm_channel_cmp #(.CW(CW)) u_cmp (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .load       (load),
      .sweep_load (sweep_load),
      .wr_hit     (wr_hit[i]),
      .wr_duty    (wr_duty),
      .sweep_step (sweep_step),
      .period     (period),
      .cnt        (cnt_q),
      .pwm_out    (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Testbench for pwm_multi_ch (CH=4, CW=8). The channel index port is one bit
// wider than strictly needed so that out-of-range writes can be driven.
module tb_pwm_multi_ch;

  logic       clk = 1'b0;
  logic       rst, en, mode_center, wr_en, sweep_en;
  logic [7:0] period, wr_duty, sweep_step;
  logic [2:0] wr_ch;
  logic [3:0] pwm_out;
  logic       cyc_done;

  int errors = 0;
  int checks = 0;

  logic [3:0] smp_pwm;
  logic       smp_cyc;

  // Reference model: position k within a cycle of known length, duties as ints.
  int         m_duty[4];
  int         m_shadow[4];
  logic [3:0] m_pwm;
  int         m_k, m_p, m_mode;

  typedef struct {
    int ch;
    int mode;
    int period;
    int duty;
    int exp_high;
    int exp_len;
  } vec_t;

  vec_t tbl[11];

  pwm_multi_ch #(.CH(4), .CW(8), .CHW(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mode_center (mode_center),
    .period      (period),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_duty     (wr_duty),
    .sweep_en    (sweep_en),
    .sweep_step  (sweep_step),
    .pwm_out     (pwm_out),
    .cyc_done    (cyc_done)
  );

  always #5 clk = ~clk;

  function automatic int m_len();
    if (m_mode != 0) return (m_p == 0) ? 1 : 2 * m_p;
    return m_p + 1;
  endfunction

  function automatic int m_cnt();
    if (m_mode != 0) return (m_k <= m_p) ? m_k : 2 * m_p - m_k;
    return m_k;
  endfunction

  function automatic int exp_cyc();
    return (en && !rst && (m_k == m_len() - 1)) ? 1 : 0;
  endfunction

  task automatic check_output(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic report_timeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got no cyc_done within 2000 clocks, expected one", name);
  endtask

  task automatic model_update();
    int         cnt, nxt;
    logic [3:0] np;
    logic       bnd;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_duty[i]   = 0;
        m_shadow[i] = 0;
      end
      m_pwm  = '0;
      m_k    = 0;
      m_p    = 0;
      m_mode = 0;
      return;
    end
    cnt = m_cnt();
    for (int i = 0; i < 4; i++) np[i] = en && (cnt < m_duty[i]);
    bnd = en && (m_k == m_len() - 1);
    if (wr_en && int'(wr_ch) < 4) m_shadow[wr_ch] = int'(wr_duty);
    if (!en || bnd) begin
      for (int i = 0; i < 4; i++) begin
        if (bnd && sweep_en) begin
          nxt       = m_duty[i] + int'(sweep_step);
          m_duty[i] = (nxt <= int'(period)) ? nxt : 0;
        end else begin
          m_duty[i] = m_shadow[i];
        end
      end
      m_k    = 0;
      m_p    = int'(period);
      m_mode = int'(mode_center);
    end else begin
      m_k++;
    end
    m_pwm = np;
  endtask

  // One clock: sample and compare at the falling edge, advance the model at
  // the rising edge, return just after it so callers can change inputs.
  task automatic apply_stimulus(input bit chk);
    @(negedge clk);
    smp_pwm = pwm_out;
    smp_cyc = cyc_done;
    if (chk) begin
      check_output("pwm_out", int'(pwm_out), int'(m_pwm));
      check_output("cyc_done", int'(cyc_done), exp_cyc());
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic sync_done();
    for (int i = 0; i < 2000; i++) begin
      apply_stimulus(1);
      if (smp_cyc) return;
    end
    report_timeout("sync_timeout");
  endtask

  // Measures one PWM cycle starting just after a cyc_done: returns the high
  // count of channel ch and the cycle length. act_kind 1 writes act_val to
  // ch at window index act_idx, act_kind 2 changes the period input there.
  task automatic measure(input int ch, input int act_idx, input int act_kind,
                         input int act_val, output int high, output int len);
    high = 0;
    len  = 0;
    for (int i = 0; i < 2000; i++) begin
      if (i == act_idx) begin
        if (act_kind == 1) begin
          wr_en   = 1'b1;
          wr_ch   = 3'(ch);
          wr_duty = 8'(act_val);
        end else begin
          period = 8'(act_val);
        end
      end
      apply_stimulus(1);
      wr_en = 1'b0;
      if (smp_pwm[ch]) high++;
      len++;
      if (smp_cyc) return;
    end
    report_timeout("window_timeout");
  endtask

  task automatic config_ch(input int ch, input int mode, input int per, input int duty);
    en          = 1'b0;
    mode_center = mode[0];
    period      = 8'(per);
    wr_en       = 1'b1;
    wr_ch       = 3'(ch);
    wr_duty     = 8'(duty);
    apply_stimulus(1);
    wr_en = 1'b0;
    apply_stimulus(1);
    en = 1'b1;
    sync_done();
    sync_done();
  endtask

  initial begin
    int h, l;
    int exp_sw[7];
    int exp_ov[4];

    tbl[0]  = '{0, 0, 9, 3, 3, 10};
    tbl[1]  = '{1, 0, 9, 0, 0, 10};
    tbl[2]  = '{2, 0, 9, 10, 10, 10};
    tbl[3]  = '{3, 0, 9, 255, 10, 10};
    tbl[4]  = '{0, 1, 4, 2, 3, 8};
    tbl[5]  = '{1, 1, 4, 4, 7, 8};
    tbl[6]  = '{2, 1, 4, 5, 8, 8};
    tbl[7]  = '{3, 1, 0, 1, 1, 1};
    tbl[8]  = '{0, 1, 0, 0, 0, 1};
    tbl[9]  = '{1, 0, 0, 1, 1, 1};
    tbl[10] = '{2, 1, 1, 1, 1, 2};
    exp_sw  = '{0, 5, 10, 15, 20, 0, 5};
    exp_ov  = '{5, 0, 255, 0};

    rst = 1'b1; en = 1'b0; mode_center = 1'b0; period = 8'd0;
    wr_en = 1'b0; wr_ch = 3'd0; wr_duty = 8'd0;
    sweep_en = 1'b0; sweep_step = 8'd0;
    m_pwm = '0; m_k = 0; m_p = 0; m_mode = 0;
    apply_stimulus(0);
    apply_stimulus(0);
    check_output("reset_pwm_out", int'(pwm_out), 0);
    check_output("reset_cyc_done", int'(cyc_done), 0);
    rst = 1'b0;

    // Steady-state high time and cycle length per configuration
    foreach (tbl[v]) begin
      config_ch(tbl[v].ch, tbl[v].mode, tbl[v].period, tbl[v].duty);
      measure(tbl[v].ch, -1, 0, 0, h, l);
      check_output($sformatf("tbl%0d_high", v), h, tbl[v].exp_high);
      check_output($sformatf("tbl%0d_len", v), l, tbl[v].exp_len);
    end

    // Duty write mid-cycle and on the boundary clock
    config_ch(0, 0, 9, 3);
    measure(0, 4, 1, 7, h, l);
    check_output("midwrite_cur_high", h, 3);
    measure(0, -1, 0, 0, h, l);
    check_output("midwrite_next_high", h, 7);
    measure(0, 9, 1, 2, h, l);
    check_output("bndwrite_cur_high", h, 7);
    measure(0, -1, 0, 0, h, l);
    check_output("bndwrite_next_high", h, 2);

    // Centre mode with a period change in the middle of a cycle
    config_ch(0, 1, 4, 2);
    measure(0, 3, 2, 6, h, l);
    check_output("ctr_cur_high", h, 3);
    check_output("ctr_cur_len", l, 8);
    measure(0, -1, 0, 0, h, l);
    check_output("ctr_new_high", h, 3);
    check_output("ctr_new_len", l, 12);

    // Sweep within period 20, then a step that carries out of 8 bits
    config_ch(0, 0, 20, 0);
    sweep_step = 8'd5;
    sweep_en   = 1'b1;
    for (int c = 0; c < 7; c++) begin
      measure(0, -1, 0, 0, h, l);
      check_output($sformatf("sweep%0d_high", c), h, exp_sw[c]);
      check_output($sformatf("sweep%0d_len", c), l, 21);
    end
    sweep_en = 1'b0;
    config_ch(0, 0, 255, 5);
    sweep_step = 8'd255;
    sweep_en   = 1'b1;
    for (int c = 0; c < 4; c++) begin
      measure(0, -1, 0, 0, h, l);
      check_output($sformatf("ovf%0d_high", c), h, exp_ov[c]);
    end
    sweep_en = 1'b0;

    // Reset mid-cycle while the output is high, then an out-of-range write
    config_ch(0, 0, 9, 8);
    for (int c = 0; c < 6; c++) apply_stimulus(1);
    rst = 1'b1;
    apply_stimulus(1);
    check_output("prereset_pwm0", int'(smp_pwm[0]), 1);
    check_output("postreset_pwm_out", int'(pwm_out), 0);
    check_output("postreset_cyc_done", int'(cyc_done), 0);
    rst = 1'b0;
    sync_done();
    measure(0, -1, 0, 0, h, l);
    check_output("postreset_high", h, 0);
    check_output("postreset_len", l, 10);
    wr_en = 1'b1; wr_ch = 3'd5; wr_duty = 8'd200;
    apply_stimulus(1);
    wr_en = 1'b0;
    sync_done();
    measure(1, -1, 0, 0, h, l);
    check_output("oob_write_ch1_high", h, 0);

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 99) == 0);
      en          = ($urandom_range(0, 9) != 0);
      mode_center = 1'($urandom_range(0, 1));
      period      = 8'($urandom_range(0, 12));
      wr_en       = ($urandom_range(0, 3) == 0);
      wr_ch       = 3'($urandom_range(0, 7));
      wr_duty     = 8'($urandom_range(0, 15));
      sweep_en    = ($urandom_range(0, 3) == 0);
      sweep_step  = 8'($urandom_range(0, 6));
      apply_stimulus(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
